// File: rtl/fact_accel.sv
// fact_accel: bus-mapped factorial engine.
// Software writes n, pokes GO, polls STATUS and then reads RESULT.
// The product is built by multiplying down from n, one factor per clock.
module fact_accel #(
    parameter int          N_W   = 4,
    parameter int unsigned N_MAX = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t          state;
    logic [N_W-1:0]  n;
    logic [N_W-1:0]  cnt;
    logic [31:0]     prod;
    logic [31:0]     result;
    logic            done;
    logic            err;
    logic            busy;
    logic            go_write;

    assign busy     = (state == CALC);
    assign go_write = we && (a == 2'd1) && wd[0];

    // Operand register, the start/compute FSM and the sticky status flags.
    // The FSM only ever reads n when it starts; cnt is its private copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            n      <= '0;
            cnt    <= '0;
            prod   <= 32'd1;
            result <= 32'd0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (we && (a == 2'd0)) begin
                n <= wd[N_W-1:0];
            end
            case (state)
                IDLE: begin
                    if (go_write) begin
                        if (32'(n) > N_MAX) begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            result <= 32'd0;
                        end else begin
                            state <= CALC;
                            cnt   <= n;
                            prod  <= 32'd1;
                            done  <= 1'b0;
                            err   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (cnt > N_W'(1)) begin
                        prod <= prod * 32'(cnt);
                        cnt  <= cnt - N_W'(1);
                    end else begin
                        result <= prod;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux straight off the registers so software sees the current state.
    always_comb begin
        rd = 32'd0;
        case (a)
            2'd0:    rd = 32'(n);
            2'd1:    rd = {31'b0, busy};
            2'd2:    rd = {30'b0, err, done};
            default: rd = result;
        endcase
    end

endmodule

// File: doc/fact_accel.md
FACT_ACCEL -- requirements
Module: fact_accel

Interface
REQ-001 The block SHALL have parameter N_W, default 4, meaning the operand n register width in bits.
REQ-002 The block SHALL have parameter N_MAX, default 12, meaning the largest n whose factorial fits 32 bits; n > N_MAX is an error.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port we  input  1  bus write enable; a write occurs on a rising edge with we=1.
REQ-006 Port a  input  2  word address selecting the register: 0=N, 1=GO, 2=STATUS, 3=RESULT.
REQ-007 Port wd  input  32  write data.
REQ-008 Port rd  output  32  read data, combinational from a and internal registers.

Function
REQ-009 Register map (rd): a=0 -> {zeros, n[N_W-1:0]}; a=1 -> {31'b0, busy}; a=2 -> {30'b0, err, done}; a=3 -> result[31:0].
REQ-010 Write a=0: n <= wd[N_W-1:0], accepted in any state; an in-flight computation uses its captured copy and is unaffected.
REQ-011 Write a=1 with wd[0]=1 while IDLE: start (edge E0); wd[0]=0, or any GO write while CALC, is ignored.
REQ-012 Writes to a=2 or a=3: ignored, no side effect.
REQ-013 FSM states: IDLE, CALC; busy=1 exactly in CALC.
REQ-014 At E0 with n <= N_MAX: state <= CALC, cnt <= n, prod <= 1, done <= 0, err <= 0; result keeps its old value.
REQ-015 At E0 with n > N_MAX: stay IDLE, err <= 1, done <= 1, result <= 0.
REQ-016 Each edge in CALC with cnt > 1: prod <= prod * cnt (truncated to 32 bits), cnt <= cnt - 1.
REQ-017 Each edge in CALC with cnt <= 1: result <= prod, done <= 1, state <= IDLE.
REQ-018 Latency: done rises at edge E(max(n,1)) after E0 (n=0,1 -> E1; n=5 -> E5; n=12 -> E12); from that edge rd at a=3 equals n!.
REQ-019 done and err are sticky; cleared only by the next accepted start or by reset.
REQ-020 Simultaneous write to a=0 and pending start impossible (one address per cycle); a start uses n as registered before that edge.
REQ-021 A start is accepted on the same edge that follows done (IDLE reached), with no dead cycle.

Reset
REQ-022 On a rising edge with rst=1: state <= IDLE, n <= 0, cnt <= 0, prod <= 1, result <= 0, done <= 0, err <= 0; rst overrides any simultaneous write.
REQ-023 Reset during CALC aborts the computation; result reads 0 and status reads 0 after that edge.
REQ-024 After reset rd SHALL read 0 at every address.

Verification
REQ-025 Reset, read a=0..3 -> all 0.
REQ-026 Write a=0 wd=5, write a=1 wd=1 -> busy=1 for 5 cycles, STATUS=1 at E5, RESULT=120 (0x78).
REQ-027 n=0 and n=1 -> done at E1, RESULT=1; n=12 -> done at E12, RESULT=479001600 (0x1C8CFC00).
REQ-028 n=13 then GO -> same edge STATUS=3 (err, done), RESULT=0, busy never 1.
REQ-029 n=6 GO, at E2 write a=0 wd=3 and a=1 wd=1 -> both ignored for the running job; RESULT=720 at E6; a=0 reads 3.
REQ-030 n=10 GO, assert rst at E4 -> busy=0, STATUS=0, RESULT=0, N=0 next cycle; new GO with n=4 -> RESULT=24 at E4.
